softex_x_buffer_replay: RTL

SOFTEX_X_BUFFER_REPLAY -- requirements
Module: softex_x_buffer_replay

---
 rtl/softex_pkg.sv | 26 ++
 rtl/softex_x_buffer_replay_if.sv | 15 +
 rtl/softex_replay_storage.sv | 26 ++
 rtl/softex_x_buffer_replay.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/softex_pkg.sv
// Shared types for the softex x-buffer replay block: replay mode, control word and status flags.
package softex_pkg;

    localparam int unsigned BUF_CNT_WIDTH = 8;
    localparam int unsigned BUF_OCC_WIDTH = 8;

    typedef enum logic {
        BEAT  = 1'b0,
        BLOCK = 1'b1
    } x_buffer_mode_e;

    typedef struct packed {
        x_buffer_mode_e             mode;
        logic [BUF_CNT_WIDTH-1:0]   num_loops;
        logic [BUF_CNT_WIDTH-1:0]   block_len;
    } x_buffer_replay_ctrl_t;

    typedef struct packed {
        logic                       empty;
        logic                       full;
        logic [BUF_OCC_WIDTH-1:0]   occupancy;
        logic [BUF_CNT_WIDTH-1:0]   loop_cnt;
        logic                       done;
    } x_buffer_replay_flags_t;

endpackage

// File: rtl/softex_x_buffer_replay_if.sv
// Valid/ready stream carrying data plus byte strobes; master drives, slave accepts.
interface softex_x_buffer_replay_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport master (output valid, output data, output strb, input  ready);
    modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/softex_replay_storage.sv
// Flop-array storage for the replay buffer: one synchronous write port, one asynchronous read port.
module softex_replay_storage #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Data entries carry no reset; occupancy tracking decides what is meaningful.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/softex_x_buffer_replay.sv
// Circular replay buffer: re-emits each stored beat (BEAT) or block of beats (BLOCK) a programmable
// number of times before popping. Optional assertions under SOFTEX_X_BUFFER_REPLAY_ASSERT_EN.
module softex_x_buffer_replay
    import softex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = BUF_CNT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  x_buffer_replay_ctrl_t  ctrl_i,
    output x_buffer_replay_flags_t flags_o,
    softex_x_buffer_replay_if.slave  buffer_i,
    softex_x_buffer_replay_if.master buffer_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned OCC_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = DATA_WIDTH + STRB_WIDTH;

    localparam logic [PTR_W:0]   DEPTH_P = (PTR_W + 1)'(DEPTH);
    localparam logic [OCC_W-1:0] DEPTH_O = OCC_W'(DEPTH);

    x_buffer_replay_ctrl_t  r_ctrl;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_head;
    logic [OCC_W-1:0]       r_occ;
    logic [PTR_W-1:0]       r_beat_cnt;
    logic [CNT_WIDTH-1:0]   r_loop_cnt;

    logic [CNT_WIDTH-1:0]   w_loops;
    logic [OCC_W-1:0]       w_blk;
    logic                   w_valid;
    logic                   w_hs;
    logic                   w_beat_last;
    logic                   w_loop_last;
    logic                   w_pop;
    logic                   w_ready_in;
    logic                   w_push;
    logic [PTR_W-1:0]       w_raddr;
    logic [ENTRY_W-1:0]     w_rdata;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W:0] a, input logic [PTR_W:0] b);
        logic [PTR_W:0] s;
        s = a + b;
        if (s >= DEPTH_P) begin
            s = s - DEPTH_P;
        end
        return s[PTR_W-1:0];
    endfunction

    // Effective loop count and block length; a zero field behaves as one.
    always_comb begin
        w_loops = (r_ctrl.num_loops == '0) ? CNT_WIDTH'(1) : CNT_WIDTH'(r_ctrl.num_loops);
        if (r_ctrl.mode == BEAT) begin
            w_blk = OCC_W'(1);
        end else if (r_ctrl.block_len == '0) begin
            w_blk = OCC_W'(1);
        end else if (32'(r_ctrl.block_len) >= DEPTH) begin
            w_blk = DEPTH_O;
        end else begin
            w_blk = OCC_W'(r_ctrl.block_len);
        end
    end

    assign w_valid     = (r_occ >= w_blk);
    assign w_hs        = w_valid & buffer_o.ready;
    assign w_beat_last = (OCC_W'(r_beat_cnt) == (w_blk - OCC_W'(1)));
    assign w_loop_last = (r_loop_cnt == (w_loops - CNT_WIDTH'(1)));
    assign w_pop       = w_hs & w_beat_last & w_loop_last;

    // A final pop frees a slot in the same cycle, so a full buffer may still accept a beat.
    assign w_ready_in  = (r_occ < DEPTH_O) | w_pop;
    assign w_push      = buffer_i.valid & w_ready_in;
    assign w_raddr     = wrap_add({1'b0, r_head}, {1'b0, r_beat_cnt});

    softex_replay_storage #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk_i   (clk_i),
        .we_i    (w_push & ~clear_i),
        .waddr_i (r_wr_ptr),
        .wdata_i ({buffer_i.strb, buffer_i.data}),
        .raddr_i (w_raddr),
        .rdata_o (w_rdata)
    );

    // Control is sampled only while empty so a replay never sees a mid-stream change.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ctrl <= '0;
        end else if (r_occ == '0) begin
            r_ctrl <= ctrl_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_head     <= '0;
            r_occ      <= '0;
            r_beat_cnt <= '0;
            r_loop_cnt <= '0;
        end else if (clear_i) begin
            r_wr_ptr   <= '0;
            r_head     <= '0;
            r_occ      <= '0;
            r_beat_cnt <= '0;
            r_loop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= wrap_add({1'b0, r_wr_ptr}, (PTR_W + 1)'(1));
            end
            r_occ <= r_occ + OCC_W'(w_push) - (w_pop ? w_blk : OCC_W'(0));
            if (w_hs) begin
                if (w_beat_last) begin
                    r_beat_cnt <= '0;
                    if (w_loop_last) begin
                        r_loop_cnt <= '0;
                        r_head     <= wrap_add({1'b0, r_head}, (PTR_W + 1)'(w_blk));
                    end else begin
                        r_loop_cnt <= r_loop_cnt + CNT_WIDTH'(1);
                    end
                end else begin
                    r_beat_cnt <= r_beat_cnt + PTR_W'(1);
                end
            end
        end
    end

    assign buffer_i.ready = w_ready_in;
    assign buffer_o.valid = w_valid;
    assign buffer_o.data  = w_rdata[DATA_WIDTH-1:0];
    assign buffer_o.strb  = w_rdata[ENTRY_W-1:DATA_WIDTH];

    assign flags_o.empty     = (r_occ == '0);
    assign flags_o.full      = (r_occ == DEPTH_O);
    assign flags_o.occupancy = BUF_OCC_WIDTH'(r_occ);
    assign flags_o.loop_cnt  = BUF_CNT_WIDTH'(r_loop_cnt);
    assign flags_o.done      = w_pop & ~clear_i;

`ifdef SOFTEX_X_BUFFER_REPLAY_ASSERT_EN
    a_ctrl_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        (r_occ != '0) |-> (ctrl_i == r_ctrl));

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && !w_pop && (r_occ == DEPTH_O)));

    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        (buffer_o.valid && !buffer_o.ready) |=>
            (buffer_o.valid && $stable(buffer_o.data) && $stable(buffer_o.strb)));
`else
    // Assertions compiled out in this build.
`endif

endmodule
